conv_frame_seq: RTL

//  Frame-level sequencer for the 2D-conv memory controller. Drives its {eop,sop} state code and chblk column strobe.

---
 rtl/conv_frame_seq.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/conv_frame_seq.sv
// Frame-level sequencer for the 2D-conv memory controller: fill, then PROC -> OUT -> LOAD per output column.
// Optional cycle counter o_frame_cycles is built only when CONV_FSEQ_PERF_EN is defined.
module conv_frame_seq #(
    parameter int N           = 2,
    parameter int COL_LEN     = 440,
    parameter int IMG_COLS    = 440,
    parameter int PROC_CYCLES = 4,
    localparam int AW = $clog2(COL_LEN),
    localparam int CW = $clog2(IMG_COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_wr_valid,
    input  logic          i_rd_ready,
    output logic          o_sop,
    output logic          o_eop,
    output logic          o_chblk,
    output logic [AW-1:0] o_wr_addr,
    output logic [AW-1:0] o_rd_addr,
    output logic          o_rd_valid,
    output logic          o_busy,
    output logic          o_frame_done,
`ifdef CONV_FSEQ_PERF_EN
    output logic [31:0]   o_frame_cycles,
`endif
    output logic [CW-1:0] o_col_idx
);

    localparam int FW = $clog2(N + 2);
    localparam int PW = $clog2(PROC_CYCLES + 1);

    // State encoding doubles as the {eop,sop} code seen by the memory controller.
    typedef enum logic [1:0] {
        S_LOAD = 2'b00,
        S_PROC = 2'b01,
        S_OUT  = 2'b10,
        S_IDLE = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [CW-1:0] col_idx_q, col_idx_d;
    logic [FW-1:0] loaded_q, loaded_d;
    logic [PW-1:0] proc_cnt_q, proc_cnt_d;
    logic          chblk_q, chblk_d;
    logic          rd_valid_q, rd_valid_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;

    logic          start_acc;
    logic          wr_last;
    logic          rd_last;
    logic          fill_done;
    logic          proc_done;
    logic          frame_end;
    logic [FW-1:0] target;

    assign start_acc = (state_q == S_IDLE) && i_start;
    assign wr_last   = i_wr_valid && (wr_addr_q == AW'(COL_LEN - 1));
    assign rd_last   = i_rd_ready && (rd_addr_q == AW'(COL_LEN - 1));
    // Before the first output column the banks need N+1 columns; afterwards one column refills.
    assign target    = (col_idx_q == '0) ? FW'(N + 1) : FW'(1);
    assign fill_done = wr_last && ((loaded_q + 1'b1) == target);
    assign proc_done = (proc_cnt_q == PW'(PROC_CYCLES - 1));
    assign frame_end = rd_last && ((col_idx_q + 1'b1) == CW'(IMG_COLS - N));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            col_idx_q    <= '0;
            loaded_q     <= '0;
            proc_cnt_q   <= '0;
            chblk_q      <= 1'b0;
            rd_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            col_idx_q    <= col_idx_d;
            loaded_q     <= loaded_d;
            proc_cnt_q   <= proc_cnt_d;
            chblk_q      <= chblk_d;
            rd_valid_q   <= rd_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start)   state_d = S_LOAD;
            S_LOAD:  if (fill_done) state_d = S_PROC;
            S_PROC:  if (proc_done) state_d = S_OUT;
            S_OUT:   if (rd_last)   state_d = frame_end ? S_IDLE : S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        col_idx_d    = col_idx_q;
        loaded_d     = loaded_q;
        proc_cnt_d   = proc_cnt_q;
        chblk_d      = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    col_idx_d = '0;
                    loaded_d  = '0;
                    wr_addr_d = '0;
                    rd_addr_d = '0;
                end
            end
            S_LOAD: begin
                proc_cnt_d = '0;
                if (i_wr_valid) begin
                    if (wr_last) begin
                        wr_addr_d = '0;
                        chblk_d   = 1'b1;
                        loaded_d  = fill_done ? '0 : loaded_q + 1'b1;
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                    end
                end
            end
            S_PROC: begin
                rd_addr_d  = '0;
                proc_cnt_d = proc_done ? '0 : proc_cnt_q + 1'b1;
            end
            S_OUT: begin
                if (i_rd_ready) begin
                    if (rd_last) begin
                        rd_addr_d    = '0;
                        chblk_d      = 1'b1;
                        col_idx_d    = col_idx_q + 1'b1;
                        frame_done_d = frame_end;
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        rd_valid_d = (state_d == S_OUT);
        busy_d     = (state_d != S_IDLE);
    end

`ifdef CONV_FSEQ_PERF_EN
    logic [31:0] frame_cycles_q, frame_cycles_d;

    always_comb begin
        frame_cycles_d = frame_cycles_q;
        if (start_acc)   frame_cycles_d = '0;
        else if (busy_q) frame_cycles_d = frame_cycles_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) frame_cycles_q <= '0;
        else      frame_cycles_q <= frame_cycles_d;
    end

    assign o_frame_cycles = frame_cycles_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

    assign o_sop        = state_q[0];
    assign o_eop        = state_q[1];
    assign o_chblk      = chblk_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_rd_valid   = rd_valid_q;
    assign o_busy       = busy_q;
    assign o_frame_done = frame_done_q;
    assign o_col_idx    = col_idx_q;

endmodule
